// File: rtl/turn_scheduler.sv
// Turn sequencer: owns the active player, the per-turn countdown, the round
// counter and end-of-game detection for the game logic clock domain.
module turn_scheduler #(
    parameter int MAX_PLAYER_CNT      = 7,
    parameter int LOG2_MAX_PLAYER_CNT = $clog2(MAX_PLAYER_CNT + 1),
    parameter int LOG2_MAX_ROUND      = 12,
    parameter int ROUND_LIMIT         = 999,
    parameter int MAX_STEP_TIME       = 15,
    parameter int LOG2_MAX_STEP_TIME  = $clog2(MAX_STEP_TIME),
    parameter int TICKS_PER_SECOND    = 50_000_000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [LOG2_MAX_PLAYER_CNT-1:0] first_player,
    input  logic [MAX_PLAYER_CNT:0]        alive_mask,
    input  logic                           step_done,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
    output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
    output logic [LOG2_MAX_ROUND-1:0]      round,
    output logic                           turn_start,
    output logic                           round_tick,
    output logic                           timeout,
    output logic [1:0]                     state,
    output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

    localparam int PW = LOG2_MAX_PLAYER_CNT;
    localparam int SW = LOG2_MAX_STEP_TIME;
    localparam int RW = LOG2_MAX_ROUND;
    localparam int TW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;

    typedef logic [PW-1:0] pid_t;
    typedef logic [MAX_PLAYER_CNT:0] mask_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        IN_TURN   = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam pid_t            MAX_ID    = pid_t'(MAX_PLAYER_CNT);
    localparam pid_t            PID_ONE   = pid_t'(1);
    localparam logic [SW-1:0]   ST_MAX    = SW'(MAX_STEP_TIME);
    localparam logic [SW-1:0]   ST_ONE    = SW'(1);
    localparam logic [RW-1:0]   RND_ONE   = RW'(1);
    localparam logic [RW-1:0]   RND_LIMIT = RW'(ROUND_LIMIT);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_SECOND - 1);
    localparam logic [TW-1:0]   TICK_ONE  = TW'(1);

    // Player 0 is the NPC; its liveness bit carries no meaning here.
    logic unused_npc_alive;
    assign unused_npc_alive = alive_mask[0];

    state_t         state_q, state_d;
    pid_t           cand_q, cand_d;
    pid_t           cur_q, cur_d;
    pid_t           next_q, next_d;
    pid_t           winner_q, winner_d;
    logic [SW-1:0]  timer_q, timer_d;
    logic [RW-1:0]  round_q, round_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic           turn_start_q, turn_start_d;
    logic           round_tick_q, round_tick_d;
    logic           timeout_q, timeout_d;

    function automatic logic bit_at(input mask_t mask, input int i);
        mask_t sh;
        sh = mask >> i;
        return sh[0];
    endfunction

    function automatic pid_t wrap_id(input pid_t c);
        return (c == '0 || c >= MAX_ID) ? PID_ONE : c + PID_ONE;
    endfunction

    function automatic logic id_alive(input pid_t id, input mask_t mask);
        logic r;
        r = 1'b0;
        for (int i = 1; i <= MAX_PLAYER_CNT; i++)
            if (id == pid_t'(i)) r = bit_at(mask, i);
        return r;
    endfunction

    // First alive id strictly after cur, wrapping back to the lowest alive id.
    function automatic pid_t next_alive(input pid_t cur, input mask_t mask);
        pid_t hi, lo;
        hi = '0;
        lo = '0;
        for (int i = MAX_PLAYER_CNT; i >= 1; i--) begin
            if (bit_at(mask, i)) begin
                lo = pid_t'(i);
                if (pid_t'(i) > cur) hi = pid_t'(i);
            end
        end
        return (hi != '0) ? hi : lo;
    endfunction

    pid_t alive_cnt;
    pid_t last_alive;
    pid_t adv_from;
    logic do_adv;
    logic tick_wrap;
    logic expire;
    logic cur_alive;

    always_comb begin
        alive_cnt  = '0;
        last_alive = '0;
        for (int i = 1; i <= MAX_PLAYER_CNT; i++) begin
            if (bit_at(alive_mask, i)) begin
                alive_cnt  = alive_cnt + PID_ONE;
                last_alive = pid_t'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cur_d        = cur_q;
        winner_d     = winner_q;
        timer_d      = timer_q;
        round_d      = round_q;
        tick_d       = tick_q;
        turn_start_d = 1'b0;
        round_tick_d = 1'b0;
        timeout_d    = 1'b0;
        do_adv       = 1'b0;
        adv_from     = (state_q == IN_TURN) ? cur_q : cand_q;
        tick_wrap    = (tick_q == TICK_LAST);
        expire       = tick_wrap && (timer_q == ST_ONE);
        cur_alive    = id_alive(cur_q, alive_mask);

        case (state_q)
            IDLE: begin
                if (start) begin
                    cand_d  = first_player;
                    round_d = RND_ONE;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (id_alive(cand_q, alive_mask)) begin
                    cur_d        = cand_q;
                    timer_d      = ST_MAX;
                    tick_d       = '0;
                    turn_start_d = 1'b1;
                    state_d      = IN_TURN;
                end else begin
                    do_adv = 1'b1;
                end
            end
            IN_TURN: begin
                tick_d = tick_wrap ? '0 : tick_q + TICK_ONE;
                if (tick_wrap) timer_d = timer_q - ST_ONE;
                if (step_done || !cur_alive || expire) begin
                    state_d   = SEARCH;
                    cur_d     = '0;
                    do_adv    = 1'b1;
                    // Expiry is the lowest-priority cause, so it only counts
                    // when neither of the others is present.
                    timeout_d = !step_done && cur_alive;
                end
            end
            default: ;
        endcase

        // Passing the highest id closes a round, including the turn-end wrap.
        if (do_adv) begin
            cand_d = wrap_id(adv_from);
            if (adv_from >= MAX_ID) begin
                if (round_q == RND_LIMIT) begin
                    state_d  = GAME_OVER;
                    winner_d = '0;
                end else begin
                    round_d      = round_q + RND_ONE;
                    round_tick_d = 1'b1;
                end
            end
        end

        // Too few survivors ends the game ahead of any other transition.
        if ((state_q == SEARCH || state_q == IN_TURN) && alive_cnt <= PID_ONE) begin
            state_d      = GAME_OVER;
            winner_d     = (alive_cnt == '0) ? '0 : last_alive;
            cur_d        = '0;
            cand_d       = cand_q;
            timer_d      = timer_q;
            round_d      = round_q;
            tick_d       = tick_q;
            turn_start_d = 1'b0;
            round_tick_d = 1'b0;
            timeout_d    = 1'b0;
        end

        next_d = (state_q == IN_TURN) ? next_alive(cur_q, alive_mask) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            cur_q        <= '0;
            next_q       <= '0;
            winner_q     <= '0;
            timer_q      <= '0;
            round_q      <= '0;
            tick_q       <= '0;
            turn_start_q <= 1'b0;
            round_tick_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cur_q        <= cur_d;
            next_q       <= next_d;
            winner_q     <= winner_d;
            timer_q      <= timer_d;
            round_q      <= round_d;
            tick_q       <= tick_d;
            turn_start_q <= turn_start_d;
            round_tick_q <= round_tick_d;
            timeout_q    <= timeout_d;
        end
    end

    assign current_player = cur_q;
    assign next_player    = next_q;
    assign step_timer     = timer_q;
    assign round          = round_q;
    assign turn_start     = turn_start_q;
    assign round_tick     = round_tick_q;
    assign timeout        = timeout_q;
    assign state          = state_q;
    assign winner         = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a turn/round scoreboard fed by the
// stimulus and drained by a monitor on turn_start / round_tick pulses.
module tb_turn_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  first_player;
    logic [7:0]  alive_mask;
    logic        step_done;
    logic [2:0]  current_player;
    logic [2:0]  next_player;
    logic [3:0]  step_timer;
    logic [11:0] round;
    logic        turn_start;
    logic        round_tick;
    logic        timeout;
    logic [1:0]  state;
    logic [2:0]  winner;

    int checks   = 0;
    int failures = 0;
    int exp_player[$];
    int exp_round[$];

    always #5 clock = ~clock;

    turn_scheduler #(
        .MAX_PLAYER_CNT   (7),
        .LOG2_MAX_ROUND   (12),
        .ROUND_LIMIT      (999),
        .MAX_STEP_TIME    (15),
        .TICKS_PER_SECOND (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .first_player   (first_player),
        .alive_mask     (alive_mask),
        .step_done      (step_done),
        .current_player (current_player),
        .next_player    (next_player),
        .step_timer     (step_timer),
        .round          (round),
        .turn_start     (turn_start),
        .round_tick     (round_tick),
        .timeout        (timeout),
        .state          (state),
        .winner         (winner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {state, current_player, next_player, step_timer, round, winner,
                  turn_start, round_tick, timeout}, 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard drain: every pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (turn_start === 1'b1) begin
            checks++;
            assert (exp_player.size() > 0) else begin
                failures++;
                $error("FAIL sb_turn_start: observed unexpected turn for player %0d, expected none", current_player);
            end
            if (exp_player.size() > 0) chk("sb_player", current_player, exp_player.pop_front());
        end
        if (round_tick === 1'b1) begin
            checks++;
            assert (exp_round.size() > 0) else begin
                failures++;
                $error("FAIL sb_round_tick: observed unexpected tick at round %0d, expected none", round);
            end
            if (exp_round.size() > 0) chk("sb_round", round, exp_round.pop_front());
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; first_player = '0; alive_mask = '0; step_done = 1'b0;
        tick(2);
        chk_zero("reset_state");
        reset = 1'b0;

        // Test 1: start with players 1 and 2 alive
        alive_mask = 8'b0000_0110; first_player = 3'd1; start = 1'b1;
        exp_player.push_back(1);
        tick(1);
        start = 1'b0;
        chk("t1_search_state", state, 1);
        chk("t1_round", round, 1);
        tick(1);
        chk("t1_in_turn", state, 2);
        chk("t1_player", current_player, 1);
        chk("t1_timer", step_timer, 15);
        chk("t1_turn_start", turn_start, 1);
        tick(1);
        chk("t1_next", next_player, 2);
        chk("t1_turn_start_low", turn_start, 0);

        // Test 2: idle turn expires after 60 IN_TURN cycles
        exp_player.push_back(2);
        for (int k = 1; k < 60; k++) begin
            if (k % 4 == 0) chk("t2_timer", step_timer, 15 - k / 4);
            if (k == 59) begin
                chk("t2_last_state", state, 2);
                chk("t2_last_timer", step_timer, 1);
                chk("t2_no_early_timeout", timeout, 0);
            end
            tick(1);
        end
        chk("t2_timeout", timeout, 1);
        chk("t2_search", state, 1);
        chk("t2_timer_zero", step_timer, 0);
        tick(1);
        chk("t2_player2", current_player, 2);
        chk("t2_timeout_low", timeout, 0);
        chk("t2_round", round, 1);

        // Test 3: player 2 commits; search 3..7 wraps to player 1, round 2
        step_done = 1'b1;
        exp_round.push_back(2);
        exp_player.push_back(1);
        tick(1);
        step_done = 1'b0;
        chk("t3_search", state, 1);
        tick(5);
        chk("t3_round", round, 2);
        chk("t3_round_tick", round_tick, 1);
        tick(1);
        chk("t3_player1", current_player, 1);
        chk("t3_round_tick_low", round_tick, 0);

        // Test 5: player 2 dies mid-turn leaving only player 1
        step_done = 1'b1;
        exp_player.push_back(2);
        tick(1);
        step_done = 1'b0;
        tick(1);
        chk("t5_player2", current_player, 2);
        alive_mask = 8'b0000_0010;
        tick(1);
        chk("t5_game_over", state, 3);
        chk("t5_winner", winner, 1);
        chk("t5_player_zero", current_player, 0);
        start = 1'b1; step_done = 1'b1;
        tick(1);
        start = 1'b0; step_done = 1'b0;
        tick(2);
        chk("t5_stays_over", state, 3);
        chk("t5_round_frozen", round, 2);
        chk("t5_next_zero", next_player, 0);

        // Test 4: search from NPC candidate, then a long search to player 7
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero("t4_reset");
        alive_mask = 8'b1000_0100; first_player = 3'd0; start = 1'b1;
        exp_player.push_back(2);
        tick(1);
        start = 1'b0;
        tick(2);
        chk("t4_still_search", state, 1);
        chk("t4_no_round_on_npc", round, 1);
        tick(1);
        chk("t4_player2", current_player, 2);
        tick(1);
        chk("t4_next7", next_player, 7);
        step_done = 1'b1;
        exp_player.push_back(7);
        tick(1);
        step_done = 1'b0;
        chk("t4_search_pl0", current_player, 0);
        tick(4);
        chk("t4_search_4", state, 1);
        tick(1);
        chk("t4_player7", current_player, 7);
        tick(1);
        chk("t4_next_wrap", next_player, 2);
        chk("t4_round", round, 1);

        // Reset mid-turn alongside a wrapping step_done: no pulses, all zero
        reset = 1'b1; step_done = 1'b1;
        tick(1);
        chk_zero("reset_midturn");
        reset = 1'b0; step_done = 1'b0;

        // Turn ended by the player's own death, then step_done on the expiry cycle
        alive_mask = 8'b0000_1110; first_player = 3'd1; start = 1'b1;
        exp_player.push_back(1);
        tick(1);
        start = 1'b0;
        tick(1);
        chk("dead_player1", current_player, 1);
        alive_mask = 8'b0000_1100;
        exp_player.push_back(2);
        tick(1);
        chk("dead_search", state, 1);
        chk("dead_no_timeout", timeout, 0);
        tick(1);
        chk("dead_player2", current_player, 2);
        tick(59);
        step_done = 1'b1;
        exp_player.push_back(3);
        tick(1);
        step_done = 1'b0;
        chk("simul_search", state, 1);
        chk("simul_no_timeout", timeout, 0);
        tick(1);
        chk("simul_player3", current_player, 3);

        // Test 6: play instant turns until the round limit ends the game
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int r = 1; r <= 999; r++) begin
            exp_player.push_back(1);
            exp_player.push_back(2);
            if (r >= 2) exp_round.push_back(r);
        end
        alive_mask = 8'b0000_0110; first_player = 3'd1; start = 1'b1; step_done = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 20000 && state != 2'd3; i++) tick(1);
        step_done = 1'b0;
        chk("t6_game_over", state, 3);
        chk("t6_winner_draw", winner, 0);
        chk("t6_round_held", round, 999);
        chk("t6_player_zero", current_player, 0);
        tick(2);
        chk("t6_round_frozen", round, 999);
        chk("sb_player_drain", exp_player.size(), 0);
        chk("sb_round_drain", exp_round.size(), 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero("t6_reset");
        tick(2);
        chk("t6_idle_hold", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
